plc_io_image: RTL and testbench

- Input/output image stage for the ladder scan engine.
- Input side: synchronises and debounces raw switch/key inputs, then freezes them into an input image once per scan.
- Handshake: issues scan_start to the rung engine and waits for scan_done.
- Output side: commits the engine's coil image to the physical output latch, with a scan watchdog that forces outputs safe when a scan hangs.

---
 rtl/plc_io_image.sv | 217 +++++++++++++++++++++
 tb/tb_plc_io_image.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plc_io_image.sv
// -----------------------------------------------------------------------------
// plc_io_image
//
// Input/output image stage for the ladder scan engine.
//   * Raw switch/key inputs are brought into the clock domain by a 2-flop
//     synchroniser and then debounced per bit. An input change is accepted
//     only after DEB_CYCLES consecutive cycles at the new level.
//   * Once per scan, in the SAMPLE state, the debounced inputs are frozen into
//     in_img. The per-bit edges relative to the previous image are reported on
//     in_rise and in_fall.
//   * scan_start tells the rung engine that a scan has begun. When the engine
//     answers with scan_done, its coil image is committed to out_phys.
//   * A scan watchdog limits the RUN state to WDT_CYCLES cycles. On expiry the
//     outputs are forced to 0 and the block waits in FAULT for fault_clr.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   raw_in      physical inputs, active-high, asynchronous to clk
//   scan_done   one-cycle pulse from the rung engine; coil_img valid this cycle
//   coil_img    coil image from the rung engine
//   fault_clr   one-cycle pulse: leave FAULT
//   scan_start  one-cycle pulse: new scan begins, in_img valid
//   in_img      frozen debounced input image
//   in_rise     per-bit 0->1 transitions since the previous image
//   in_fall     per-bit 1->0 transitions since the previous image
//   out_phys    registered physical outputs
//   wdt_fault   watchdog fault flag
//   scan_count  completed-scan counter (wraps)
//
// Every output comes straight from a flop. No input has a combinational path
// to an output.
// -----------------------------------------------------------------------------
module plc_io_image #(
   parameter int N_IN       = 8,
   parameter int N_OUT      = 19,
   parameter int DEB_CYCLES = 1000,
   parameter int WDT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  raw_in,
   input  logic             scan_done,
   input  logic [N_OUT-1:0] coil_img,
   input  logic             fault_clr,
   output logic             scan_start,
   output logic [N_IN-1:0]  in_img,
   output logic [N_IN-1:0]  in_rise,
   output logic [N_IN-1:0]  in_fall,
   output logic [N_OUT-1:0] out_phys,
   output logic             wdt_fault,
   output logic [15:0]      scan_count
);

   localparam int DCW = $clog2(DEB_CYCLES);
   localparam int WCW = $clog2(WDT_CYCLES);
   localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
   localparam logic [WCW-1:0] WDT_LAST = WCW'(WDT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SAMPLE = 2'd0,
      ST_RUN    = 2'd1,
      ST_FAULT  = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // Synchroniser and debounce
   // ---------------------------------------------------------------------------
   logic [N_IN-1:0] sync1_q;
   logic [N_IN-1:0] sync2_q;
   logic [N_IN-1:0] deb_state_q;
   logic [N_IN-1:0] deb_state_d;
   logic [DCW-1:0]  deb_cnt_q [N_IN];
   logic [DCW-1:0]  deb_cnt_d [N_IN];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_state_q <= '0;
         // NOTE: the debounce counters are an array, but each one is real
         // control state. They are cleared element by element so that no
         // stale count survives a reset and lets a short glitch through.
         for (int i = 0; i < N_IN; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         // NOTE: sequential state is always written with non-blocking
         // assignments. The two synchroniser stages then shift by exactly one
         // flop per edge, whatever order the statements are written in.
         sync1_q     <= raw_in;
         sync2_q     <= sync1_q;
         deb_state_q <= deb_state_d;
         for (int i = 0; i < N_IN; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
      end
   end

   // The counter measures how long sync2_q has disagreed with the accepted
   // level. Any agreement restarts the count, so a glitch shorter than
   // DEB_CYCLES cycles never reaches deb_state_q.
   always_comb begin
      // NOTE: every combinational output is given a default before any
      // branch. No path can leave a signal unassigned, so no latch is inferred.
      deb_state_d = deb_state_q;
      for (int i = 0; i < N_IN; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_state_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               deb_state_d[i] = ~deb_state_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scan state machine, image registers and output latch
   // ---------------------------------------------------------------------------
   state_e           state_q,      state_d;
   logic [WCW-1:0]   wdt_q,        wdt_d;
   logic             scan_start_q, scan_start_d;
   logic [N_IN-1:0]  in_img_q,     in_img_d;
   logic [N_IN-1:0]  in_rise_q,    in_rise_d;
   logic [N_IN-1:0]  in_fall_q,    in_fall_d;
   logic [N_OUT-1:0] out_phys_q,   out_phys_d;
   logic             wdt_fault_q,  wdt_fault_d;
   logic [15:0]      scan_count_q, scan_count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_SAMPLE;
         wdt_q        <= '0;
         scan_start_q <= 1'b0;
         in_img_q     <= '0;
         in_rise_q    <= '0;
         in_fall_q    <= '0;
         out_phys_q   <= '0;
         wdt_fault_q  <= 1'b0;
         scan_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wdt_q        <= wdt_d;
         scan_start_q <= scan_start_d;
         in_img_q     <= in_img_d;
         in_rise_q    <= in_rise_d;
         in_fall_q    <= in_fall_d;
         out_phys_q   <= out_phys_d;
         wdt_fault_q  <= wdt_fault_d;
         scan_count_q <= scan_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wdt_d        = wdt_q;
      scan_start_d = 1'b0;
      in_img_d     = in_img_q;
      in_rise_d    = in_rise_q;
      in_fall_d    = in_fall_q;
      out_phys_d   = out_phys_q;
      wdt_fault_d  = wdt_fault_q;
      scan_count_d = scan_count_q;

      unique case (state_q)
         ST_SAMPLE: begin
            // Edges are taken against the image being replaced.
            in_img_d     = deb_state_q;
            in_rise_d    = deb_state_q & ~in_img_q;
            in_fall_d    = ~deb_state_q & in_img_q;
            scan_start_d = 1'b1;
            wdt_d        = '0;
            state_d      = ST_RUN;
         end

         ST_RUN: begin
            wdt_d = wdt_q + WCW'(1);
            // A scan that completes on the expiry cycle still commits, so
            // scan_done is tested before the watchdog.
            if (scan_done) begin
               out_phys_d   = coil_img;
               scan_count_d = scan_count_q + 16'd1;
               state_d      = ST_SAMPLE;
            end else if (wdt_q == WDT_LAST) begin
               out_phys_d  = '0;
               wdt_fault_d = 1'b1;
               state_d     = ST_FAULT;
            end
         end

         ST_FAULT: begin
            // Outputs stay safe until a later scan commits a new image.
            out_phys_d  = '0;
            wdt_fault_d = 1'b1;
            if (fault_clr) begin
               wdt_fault_d = 1'b0;
               state_d     = ST_SAMPLE;
            end
         end

         default: begin
            state_d = ST_SAMPLE;
         end
      endcase
   end

   assign scan_start = scan_start_q;
   assign in_img     = in_img_q;
   assign in_rise    = in_rise_q;
   assign in_fall    = in_fall_q;
   assign out_phys   = out_phys_q;
   assign wdt_fault  = wdt_fault_q;
   assign scan_count = scan_count_q;

endmodule

// File: tb/tb_plc_io_image.sv
// -----------------------------------------------------------------------------
// tb_plc_io_image
//
// Self-checking bench for plc_io_image (N_IN=4, N_OUT=8, DEB_CYCLES=4,
// WDT_CYCLES=16). A behavioural reference model is kept in the bench:
//   * a 2-deep history queue stands in for the input synchroniser delay,
//   * per bit, the number of consecutive disagreeing cycles is counted,
//   * the scan is tracked as "faulted" plus the age of the current scan.
// Every cycle, all outputs are compared against the model on the falling
// edge. Directed checks with fixed expected values cover the notable points.
// -----------------------------------------------------------------------------
module tb_plc_io_image;

   localparam int N_IN  = 4;
   localparam int N_OUT = 8;
   localparam int DEB   = 4;
   localparam int WDT   = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N_IN-1:0]  raw_in = '0;
   logic             scan_done = 1'b0;
   logic [N_OUT-1:0] coil_img = '0;
   logic             fault_clr = 1'b0;
   logic             scan_start;
   logic [N_IN-1:0]  in_img;
   logic [N_IN-1:0]  in_rise;
   logic [N_IN-1:0]  in_fall;
   logic [N_OUT-1:0] out_phys;
   logic             wdt_fault;
   logic [15:0]      scan_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   plc_io_image #(
      .N_IN       (N_IN),
      .N_OUT      (N_OUT),
      .DEB_CYCLES (DEB),
      .WDT_CYCLES (WDT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .scan_done  (scan_done),
      .coil_img   (coil_img),
      .fault_clr  (fault_clr),
      .scan_start (scan_start),
      .in_img     (in_img),
      .in_rise    (in_rise),
      .in_fall    (in_fall),
      .out_phys   (out_phys),
      .wdt_fault  (wdt_fault),
      .scan_count (scan_count)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [N_IN-1:0]  m_hist[$];
   int               m_run[N_IN];
   logic [N_IN-1:0]  m_deb;
   bit               m_faulted;
   int               m_age;      // -1: next edge samples; k: k-th RUN cycle
   logic             m_start;
   logic [N_IN-1:0]  m_img, m_rise, m_fall;
   logic [N_OUT-1:0] m_out;
   logic             m_fault;
   logic [15:0]      m_count;

   task automatic model_reset();
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
      for (int b = 0; b < N_IN; b++) m_run[b] = 0;
      m_deb     = '0;
      m_faulted = 1'b0;
      m_age     = -1;
      m_start   = 1'b0;
      m_img     = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_out     = '0;
      m_fault   = 1'b0;
      m_count   = '0;
   endtask

   task automatic model_step();
      logic [N_IN-1:0] seen;
      seen = m_hist.pop_front();       // raw value from two edges ago
      m_hist.push_back(raw_in);
      // The scan side sees the accepted levels from before this edge.
      if (m_faulted) begin
         m_start = 1'b0;
         m_out   = '0;
         if (fault_clr) begin
            m_faulted = 1'b0;
            m_fault   = 1'b0;
            m_age     = -1;
         end
      end else if (m_age < 0) begin
         m_rise  = m_deb & ~m_img;
         m_fall  = ~m_deb & m_img;
         m_img   = m_deb;
         m_start = 1'b1;
         m_age   = 0;
      end else begin
         m_start = 1'b0;
         if (scan_done) begin
            m_out   = coil_img;
            m_count = m_count + 16'd1;
            m_age   = -1;
         end else if (m_age == WDT - 1) begin
            m_faulted = 1'b1;
            m_fault   = 1'b1;
            m_out     = '0;
         end else begin
            m_age++;
         end
      end
      for (int b = 0; b < N_IN; b++) begin
         if (seen[b] != m_deb[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
               m_deb[b] = ~m_deb[b];
               m_run[b] = 0;
            end
         end else begin
            m_run[b] = 0;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic check_all();
      check("scan_start", 32'(scan_start), 32'(m_start));
      check("in_img",     32'(in_img),     32'(m_img));
      check("in_rise",    32'(in_rise),    32'(m_rise));
      check("in_fall",    32'(in_fall),    32'(m_fall));
      check("out_phys",   32'(out_phys),   32'(m_out));
      check("wdt_fault",  32'(wdt_fault),  32'(m_fault));
      check("scan_count", 32'(scan_count), 32'(m_count));
   endtask

   // One clock: step the model on the rising edge, compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   // Starting on RUN cycle 0: idle for run_len cycles, commit coil on the next,
   // then pass through SAMPLE back to RUN cycle 0 of the following scan.
   task automatic do_scan(input int run_len, input logic [N_OUT-1:0] coil);
      for (int i = 0; i < run_len; i++) tick();
      scan_done = 1'b1;
      coil_img  = coil;
      tick();
      scan_done = 1'b0;
      tick();
   endtask

   // Cap on total simulated time, so a stuck handshake cannot hang the run.
   initial begin
      #20_000_000;
      $display("FAIL timeout: bench did not finish (checks %0d)", n_checks);
      $fatal(1, "timeout");
   end

   logic [15:0] cnt_before;
   int          wrap_n;

   initial begin
      model_reset();

      // Reset with all raw inputs high.
      raw_in = 4'hF;
      repeat (3) @(negedge clk);
      check_all();
      check("rst_out_phys", 32'(out_phys), 32'h0);
      raw_in = 4'h0;
      rst = 1'b1;

      // First scan: scan_start on the cycle after SAMPLE, empty image.
      tick();
      check("first_start", 32'(scan_start), 32'h1);
      check("first_img",   32'(in_img),     32'h0);

      // Debounce: bit 0 rises and stays high; the next image shows it.
      raw_in = 4'h1;
      do_scan(5, 8'h00);
      check("deb_img",  32'(in_img),  32'h1);
      check("deb_rise", 32'(in_rise), 32'h1);
      check("deb_fall", 32'(in_fall), 32'h0);

      // A 3-cycle glitch on bit 1 stays invisible; in_rise clears.
      raw_in = 4'h3;
      repeat (3) tick();
      raw_in = 4'h1;
      do_scan(8, 8'h00);
      check("glitch_img", 32'(in_img),  32'h1);
      check("rise_clear", 32'(in_rise), 32'h0);

      // Commit on RUN cycle 5.
      cnt_before = m_count;
      repeat (5) tick();
      scan_done = 1'b1;
      coil_img  = 8'hA5;
      tick();
      scan_done = 1'b0;
      check("commit_out",   32'(out_phys),   32'hA5);
      check("commit_count", 32'(scan_count), 32'(cnt_before + 16'd1));
      check("commit_nostart", 32'(scan_start), 32'h0);
      coil_img = 8'h5A;
      tick();
      check("restart", 32'(scan_start), 32'h1);
      tick();
      check("coil_no_done", 32'(out_phys), 32'hA5);

      // Watchdog: 15 more RUN cycles reach the expiry cycle; then fault.
      repeat (14) tick();
      check("wdt_pre", 32'(wdt_fault), 32'h0);
      tick();
      check("wdt_fault", 32'(wdt_fault), 32'h1);
      check("wdt_out",   32'(out_phys),  32'h0);
      cnt_before = m_count;
      scan_done = 1'b1;
      coil_img  = 8'hFF;
      tick();
      scan_done = 1'b0;
      check("fault_done_out",   32'(out_phys),   32'h0);
      check("fault_done_count", 32'(scan_count), 32'(cnt_before));
      repeat (3) tick();
      check("fault_no_start", 32'(scan_start), 32'h0);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("clr_fault", 32'(wdt_fault), 32'h0);
      tick();
      check("clr_start", 32'(scan_start), 32'h1);
      check("clr_out",   32'(out_phys),   32'h0);

      // scan_done on the expiry cycle (RUN cycle 15) commits, no fault.
      repeat (15) tick();
      scan_done = 1'b1;
      coil_img  = 8'h3C;
      tick();
      scan_done = 1'b0;
      check("coinc_fault", 32'(wdt_fault), 32'h0);
      check("coinc_out",   32'(out_phys),  32'h3C);
      tick();

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) raw_in = N_IN'($urandom);
         coil_img  = N_OUT'($urandom);
         scan_done = ($urandom_range(0, 9) == 0);
         fault_clr = ($urandom_range(0, 19) == 0);
         tick();
      end
      scan_done = 1'b0;
      fault_clr = 1'b0;

      // Return to RUN cycle 0 of a fresh scan.
      for (int g = 0; g < 64 && !(m_start && !m_faulted); g++) begin
         fault_clr = m_faulted;
         tick();
      end
      fault_clr = 1'b0;
      check("resync_start", 32'(scan_start), 32'h1);

      // Minimum-length scans up to 0xFFFF, then one more wraps to 0.
      wrap_n = 65535 - int'(m_count);
      for (int s = 0; s < wrap_n; s++) begin
         scan_done = 1'b1;
         tick();
         scan_done = 1'b0;
         tick();
      end
      check("count_ffff", 32'(scan_count), 32'hFFFF);
      scan_done = 1'b1;
      tick();
      scan_done = 1'b0;
      check("count_wrap", 32'(scan_count), 32'h0);
      tick();

      // Asynchronous reset in the middle of RUN with all outputs driven high.
      do_scan(2, 8'hFF);
      repeat (3) tick();
      check("pre_rst_out", 32'(out_phys), 32'hFF);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_out",   32'(out_phys),   32'h0);
      check("async_start", 32'(scan_start), 32'h0);
      check_all();
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("resume_start", 32'(scan_start), 32'h1);
      do_scan(1, 8'h81);
      check("resume_out", 32'(out_phys), 32'h81);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
